// File: rtl/peri_pwm_ramp_ctrl.sv
// Wishbone slave holding per-channel duty targets, plus a Wishbone master that ramps each
// channel's current duty toward its target by STEP on every prescaler tick.
module peri_pwm_ramp_ctrl #(
  parameter int unsigned CHANNELS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wb_we_i,
  input  logic                wb_stb_i,
  output logic                wb_ack_o,
  input  logic [3:0]          wb_adr_i,
  input  logic [7:0]          wb_dat_i,
  output logic [7:0]          wb_dat_o,
  output logic [CHANNELS-1:0] ch_stb_o,
  output logic                ch_we_o,
  output logic [7:0]          ch_dat_o,
  input  logic [CHANNELS-1:0] ch_ack_i
);

  localparam logic [2:0] LastCh = 3'(CHANNELS - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StWrite, StNext} state_e;

  state_e              state_q;
  logic [2:0]          ch_q;
  logic [7:0]          tgt_q [8];
  logic [7:0]          cur_q [8];
  logic [15:0]         div_q;
  logic [15:0]         presc_q;
  logic [7:0]          step_q;
  logic                en_q;
  logic                ovr_q;
  logic                pend_q;
  logic                wb_ack_q;
  logic [7:0]          wb_dat_q;
  logic [CHANNELS-1:0] stb_q;
  logic [7:0]          dat_q;

  logic                wb_acc;
  logic                wb_wr;
  logic                tgt_wr;
  logic                ctrl_wr;
  logic                busy;
  logic                tick;
  logic                consume;
  logic                overrun;
  logic                ack_hit;
  logic [7:0]          rd_data;
  logic [7:0]          tgt_sel;
  logic [7:0]          cur_sel;
  logic [7:0]          mag;
  logic                up;
  logic [7:0]          new_duty;
  logic [CHANNELS-1:0] ch_sel;

  // Every access sees exactly one wait state; a held strobe acks on alternate cycles.
  assign wb_acc  = wb_stb_i & ~wb_ack_q;
  assign wb_wr   = wb_acc & wb_we_i;
  assign tgt_wr  = wb_wr & ~wb_adr_i[3] & (32'(wb_adr_i[2:0]) < CHANNELS);
  assign ctrl_wr = wb_wr & (wb_adr_i == 4'hF);
  assign busy    = (state_q != StIdle);

  assign tick    = en_q & (presc_q == div_q);
  assign consume = (state_q == StIdle) & pend_q & en_q;
  assign overrun = tick & pend_q & ~consume;
  assign ack_hit = |(ch_ack_i & stb_q);

  always_comb begin
    rd_data = 8'h00;
    if (!wb_adr_i[3]) begin
      if (32'(wb_adr_i[2:0]) < CHANNELS) begin
        rd_data = cur_q[wb_adr_i[2:0]];
      end
    end else begin
      unique case (wb_adr_i[2:0])
        3'd0:    rd_data = div_q[7:0];
        3'd1:    rd_data = div_q[15:8];
        3'd2:    rd_data = step_q;
        3'd7:    rd_data = {5'b0, ovr_q, busy, en_q};
        default: rd_data = 8'h00;
      endcase
    end
  end

  // Next duty for the channel under evaluation; clamps to the target so it never overshoots.
  always_comb begin
    tgt_sel = tgt_q[ch_q];
    cur_sel = cur_q[ch_q];
    up      = tgt_sel > cur_sel;
    mag     = up ? (tgt_sel - cur_sel) : (cur_sel - tgt_sel);
    if ((step_q == 8'h00) || (mag <= step_q)) begin
      new_duty = tgt_sel;
    end else if (up) begin
      new_duty = cur_sel + step_q;
    end else begin
      new_duty = cur_sel - step_q;
    end
  end

  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ch_sel[i] = (ch_q == 3'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_ack_q <= 1'b0;
      wb_dat_q <= 8'h00;
      div_q    <= 16'h0000;
      step_q   <= 8'h00;
      en_q     <= 1'b0;
      ovr_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        tgt_q[i] <= 8'h00;
      end
    end else begin
      wb_ack_q <= wb_acc;
      wb_dat_q <= wb_acc ? rd_data : 8'h00;
      if (tgt_wr) begin
        tgt_q[wb_adr_i[2:0]] <= wb_dat_i;
      end
      if (wb_wr && (wb_adr_i == 4'h8)) begin
        div_q[7:0] <= wb_dat_i;
      end
      if (wb_wr && (wb_adr_i == 4'h9)) begin
        div_q[15:8] <= wb_dat_i;
      end
      if (wb_wr && (wb_adr_i == 4'hA)) begin
        step_q <= wb_dat_i;
      end
      if (ctrl_wr) begin
        en_q <= wb_dat_i[0];
      end
      // A fresh overrun wins over a simultaneous write-1-to-clear.
      if (overrun) begin
        ovr_q <= 1'b1;
      end else if (ctrl_wr && wb_dat_i[2]) begin
        ovr_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= 16'h0000;
    end else if (!en_q || tick) begin
      presc_q <= 16'h0000;
    end else begin
      presc_q <= presc_q + 16'h0001;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ch_q    <= 3'd0;
      pend_q  <= 1'b0;
      stb_q   <= '0;
      dat_q   <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        cur_q[i] <= 8'h00;
      end
    end else begin
      if (!en_q) begin
        pend_q <= 1'b0;
      end else if (tick) begin
        pend_q <= 1'b1;
      end else if (consume) begin
        pend_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (pend_q && en_q) begin
            ch_q    <= 3'd0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          if (tgt_sel == cur_sel) begin
            state_q <= StNext;
          end else begin
            cur_q[ch_q] <= new_duty;
            stb_q       <= ch_sel;
            dat_q       <= new_duty;
            state_q     <= StWrite;
          end
        end
        StWrite: begin
          if (ack_hit) begin
            stb_q   <= '0;
            dat_q   <= 8'h00;
            state_q <= StNext;
          end
        end
        StNext: begin
          // Dropping EN abandons the rest of the pass.
          if ((ch_q == LastCh) || !en_q) begin
            state_q <= StIdle;
          end else begin
            ch_q    <= ch_q + 3'd1;
            state_q <= StCalc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wb_ack_o = wb_ack_q;
  assign wb_dat_o = wb_dat_q;
  assign ch_stb_o = stb_q;
  assign ch_we_o  = |stb_q;
  assign ch_dat_o = dat_q;

endmodule

// File: tb/tb_peri_pwm_ramp_ctrl.sv
// Directed bench for peri_pwm_ramp_ctrl: a pass-level ramp model feeds a write scoreboard,
// and a per-cycle monitor checks the master-side protocol.
module tb_peri_pwm_ramp_ctrl;
  localparam int unsigned CH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_we;
  logic          wb_stb;
  logic          wb_ack;
  logic [3:0]    wb_adr;
  logic [7:0]    wb_dat_w;
  logic [7:0]    wb_dat_r;
  logic [CH-1:0] ch_stb;
  logic          ch_we;
  logic [7:0]    ch_dat;
  logic [CH-1:0] ch_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_delay = 0;
  int hold = 0;
  bit model_on = 1'b1;

  int exp_ch[$];
  int exp_dat[$];
  int log_ch[$];
  int log_dat[$];
  int log_t[$];
  int wr_cnt[CH];

  int m_cur[CH];
  int m_tgt[CH];
  int m_step = 0;

  always #5 clk = ~clk;

  peri_pwm_ramp_ctrl #(.CHANNELS(CH)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .wb_we_i  (wb_we),
    .wb_stb_i (wb_stb),
    .wb_ack_o (wb_ack),
    .wb_adr_i (wb_adr),
    .wb_dat_i (wb_dat_w),
    .wb_dat_o (wb_dat_r),
    .ch_stb_o (ch_stb),
    .ch_we_o  (ch_we),
    .ch_dat_o (ch_dat),
    .ch_ack_i (ch_ack)
  );

  // Channel responder: acknowledges after ack_delay cycles of strobe (0 = same cycle).
  assign ch_ack = ((ch_stb != '0) && (hold >= ack_delay)) ? ch_stb : '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold <= 0;
    else if ((ch_stb == '0) || (ch_ack != '0)) hold <= 0;
    else hold <= hold + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // One ramp pass over all channels: every channel off target moves by STEP, clamped at target.
  function automatic void model_pass();
    for (int c = 0; c < CH; c++) begin
      int d;
      int n;
      d = m_tgt[c] - m_cur[c];
      if (d != 0) begin
        if ((m_step == 0) || ((d < 0 ? -d : d) <= m_step)) n = m_tgt[c];
        else if (d > 0) n = m_cur[c] + m_step;
        else n = m_cur[c] - m_step;
        exp_ch.push_back(c);
        exp_dat.push_back(n);
        m_cur[c] = n;
      end
    end
  endfunction

  task automatic wb_write(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    wb_stb = 1'b1; wb_we = 1'b1; wb_adr = a; wb_dat_w = d;
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_we = 1'b0;
    if (a < 4'(CH)) m_tgt[a] = int'(d);
    if (a == 4'hA) m_step = int'(d);
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    wb_stb = 1'b1; wb_we = 1'b0; wb_adr = a;
    @(posedge clk); #1;
    check("rd_ack", wb_ack, 1);
    d = wb_dat_r;
    wb_stb = 1'b0;
  endtask

  task automatic wait_sb_empty(input int budget, input string nm);
    int n = 0;
    while ((exp_ch.size() != 0) && (n < budget)) begin
      @(posedge clk);
      n++;
    end
    check(nm, exp_ch.size(), 0);
  endtask

  task automatic wait_stb(input logic [CH-1:0] mask, input int budget, input string nm);
    int n = 0;
    while (((ch_stb & mask) == '0) && (n < budget)) begin
      @(posedge clk);
      n++;
    end
    check(nm, (ch_stb & mask) != '0, 1);
  endtask

  // Per-cycle protocol monitor and scoreboard.
  initial begin
    logic [CH-1:0] prev_stb = '0;
    logic [7:0]    prev_dat = '0;
    bit            prev_taken = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        bit taken;
        check("we_is_or_stb", ch_we, |ch_stb);
        check("stb_onehot0", $onehot0(ch_stb), 1);
        if (ch_stb == '0) check("ch_dat_idle", ch_dat, 0);
        if (!wb_ack) check("wb_dat_idle", wb_dat_r, 0);
        if ((prev_stb != '0) && !prev_taken) begin
          check("stb_hold", ch_stb, prev_stb);
          check("dat_hold", ch_dat, prev_dat);
        end
        taken = (ch_stb & ch_ack) != '0;
        if (taken) begin
          int idx = 0;
          for (int i = 0; i < CH; i++) if (ch_stb[i]) idx = i;
          wr_cnt[idx]++;
          log_ch.push_back(idx);
          log_dat.push_back(int'(ch_dat));
          log_t.push_back(cyc);
          if (model_on) begin
            if (exp_ch.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_write actual=ch%0d/0x%0h required=none", idx, ch_dat);
            end else begin
              check("sb_ch", idx, exp_ch.pop_front());
              check("sb_dat", ch_dat, exp_dat.pop_front());
            end
          end
        end
        prev_stb = ch_stb;
        prev_dat = ch_dat;
        prev_taken = taken;
      end else begin
        prev_stb = '0;
        prev_taken = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int s;
    int c0;
    int c1;
    int c2;
    int c3;
    int n;
    for (int i = 0; i < CH; i++) begin
      m_cur[i] = 0; m_tgt[i] = 0; wr_cnt[i] = 0;
    end
    rst_n = 1'b0; wb_we = 1'b0; wb_stb = 1'b0; wb_adr = '0; wb_dat_w = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stb", ch_stb, 0);
    check("rst_ack", wb_ack, 0);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      wb_read(4'(a), rd);
      check("rst_reg", rd, 0);
    end

    // Ramp up channel 1 by 16 per tick, DIV=9.
    wb_write(4'h8, 8'd9);
    wb_write(4'h9, 8'd0);
    wb_write(4'hA, 8'h10);
    wb_write(4'h1, 8'h40);
    for (int p = 0; p < 5; p++) model_pass();
    check("model_up_len", exp_ch.size(), 4);
    s = log_t.size();
    wb_write(4'hF, 8'h01);
    wait_sb_empty(100, "up_done");
    repeat (15) @(posedge clk);
    check("up_count", log_t.size() - s, 4);
    if (log_t.size() >= s + 4) begin
      check("up_w0", log_dat[s], 8'h10);
      check("up_w1", log_dat[s + 1], 8'h20);
      check("up_w2", log_dat[s + 2], 8'h30);
      check("up_w3", log_dat[s + 3], 8'h40);
      check("up_ch", log_ch[s + 3], 1);
      for (int i = 0; i < 3; i++) check("up_period", log_t[s + i + 1] - log_t[s + i], 10);
    end
    wb_write(4'hF, 8'h00);
    repeat (12) @(posedge clk);
    wb_read(4'hF, rd);
    check("ctrl_idle", rd, 8'h00);
    wb_read(4'h1, rd);
    check("cur1_read", rd, 8'h40);

    // Clamp going down on channel 0.
    wb_write(4'hA, 8'h40);
    wb_write(4'h0, 8'h40);
    model_pass();
    s = log_t.size();
    wb_write(4'hF, 8'h01);
    wait_sb_empty(40, "ch0_preset");
    repeat (12) @(posedge clk);
    wb_write(4'hF, 8'h00);
    wb_write(4'hA, 8'h30);
    wb_write(4'h0, 8'h05);
    model_pass();
    model_pass();
    model_pass();
    wb_write(4'hF, 8'h01);
    wait_sb_empty(60, "down_done");
    repeat (12) @(posedge clk);
    wb_write(4'hF, 8'h00);
    check("down_count", log_t.size() - s, 3);
    if (log_t.size() >= s + 3) begin
      check("down_w0", log_dat[s], 8'h40);
      check("down_w1", log_dat[s + 1], 8'h10);
      check("down_w2", log_dat[s + 2], 8'h05);
    end
    wb_read(4'h0, rd);
    check("cur0_read", rd, 8'h05);

    // STEP=0 jumps straight to target.
    wb_write(4'hA, 8'h00);
    wb_write(4'h2, 8'hFF);
    model_pass();
    model_pass();
    s = log_t.size();
    wb_write(4'hF, 8'h01);
    wait_sb_empty(40, "step0_done");
    repeat (15) @(posedge clk);
    wb_write(4'hF, 8'h00);
    check("step0_count", log_t.size() - s, 1);
    if (log_t.size() >= s + 1) check("step0_w", log_dat[s], 8'hFF);
    wb_read(4'h2, rd);
    check("cur2_read", rd, 8'hFF);

    // Overrun: tick every cycle with slow channel acks.
    model_on = 1'b0;
    ack_delay = 3;
    wb_write(4'h8, 8'h00);
    wb_write(4'hA, 8'h10);
    wb_write(4'h0, 8'h85);
    wb_write(4'h1, 8'h00);
    wb_write(4'h2, 8'h00);
    wb_write(4'h3, 8'h80);
    wb_write(4'hF, 8'h01);
    repeat (40) @(posedge clk);
    wb_read(4'hF, rd);
    check("ovr_set", rd & 8'h05, 8'h05);
    wb_write(4'h8, 8'hFF);
    wb_write(4'hF, 8'h05);
    wb_read(4'hF, rd);
    check("ovr_clr_en", rd & 8'h05, 8'h01);
    wb_write(4'hF, 8'h00);
    n = 0;
    rd = 8'h02;
    while ((rd[1] != 1'b0) && (n < 30)) begin
      wb_read(4'hF, rd);
      n++;
    end
    check("idle_after_dis", rd, 8'h00);
    ack_delay = 0;

    // Bus corner cases.
    wb_read(4'hB, rd);
    check("rd_B", rd, 0);
    wb_read(4'hC, rd);
    check("rd_C", rd, 0);
    wb_write(4'h6, 8'h33);
    wb_read(4'h6, rd);
    check("tgt6_ignored", rd, 0);
    wb_write(4'h4, 8'h44);
    wb_read(4'h4, rd);
    check("tgt4_ignored", rd, 0);
    @(posedge clk); #1;
    wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 4'hA;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("b2b_ack", wb_ack, (i % 2) == 0);
      check("b2b_dat", wb_dat_r, ((i % 2) == 0) ? 8'h10 : 8'h00);
    end
    @(posedge clk); #1;
    wb_stb = 1'b0;

    // EN dropped while channel 0 is being written.
    wb_write(4'hA, 8'h00);
    wb_write(4'h8, 8'd9);
    wb_write(4'h0, 8'h11);
    wb_write(4'h3, 8'h22);
    c0 = wr_cnt[0]; c1 = wr_cnt[1]; c2 = wr_cnt[2]; c3 = wr_cnt[3];
    ack_delay = 3;
    wb_write(4'hF, 8'h01);
    wait_stb(4'b0001, 40, "dis_stb0");
    wb_write(4'hF, 8'h00);
    repeat (40) @(posedge clk);
    check("dis_ch0_done", wr_cnt[0] - c0, 1);
    check("dis_ch1_skip", wr_cnt[1] - c1, 0);
    check("dis_ch2_skip", wr_cnt[2] - c2, 0);
    check("dis_ch3_skip", wr_cnt[3] - c3, 0);
    wb_read(4'hF, rd);
    check("dis_ctrl", rd, 8'h00);
    wb_read(4'h0, rd);
    check("dis_cur0", rd, 8'h11);

    // Asynchronous reset in the middle of a channel write.
    ack_delay = 20;
    wb_write(4'h1, 8'h99);
    c1 = wr_cnt[1];
    wb_write(4'hF, 8'h01);
    wait_stb(4'b0010, 40, "rst_mid_stb");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_stb0", ch_stb, 0);
    check("rst_mid_we0", ch_we, 0);
    check("rst_mid_dat0", ch_dat, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack_delay = 0;
    check("rst_mid_nowrite", wr_cnt[1] - c1, 0);
    for (int a = 0; a < 16; a++) begin
      wb_read(4'(a), rd);
      check("post_rst_reg", rd, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
